// File: rtl/shift_right_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_right_seq_if
//  Purpose  : Request/result bundle for the sequential right shifter.
//             master drives the operation request and observes status/results.
//             slave is the shifter side.
//  Signals  : en      - start request
//             Rd1     - operand to shift (WIDTH bits)
//             Rd2     - unsigned shift amount (CNTW bits)
//             arith   - 0 = zero fill, 1 = sign fill
//             busy    - operation in progress
//             done    - one-cycle completion pulse
//             result  - registered result of last completed operation
//             carry   - last bit shifted out of last completed operation
//  Revision : 1.0  initial release
// ============================================================================
interface shift_right_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
);
    logic             en;
    logic [WIDTH-1:0] Rd1;
    logic [CNTW-1:0]  Rd2;
    logic             arith;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    modport master (
        output en, Rd1, Rd2, arith,
        input  busy, done, result, carry
    );

    modport slave (
        input  en, Rd1, Rd2, arith,
        output busy, done, result, carry
    );
endinterface
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shift_right_seq
//  Purpose  : Multi-cycle right shifter, one bit per clock. An accepted
//             request shifts Rd1 right by min(Rd2, WIDTH) places with zero or
//             sign fill, then pulses done for one cycle with result/carry.
//  Ports    : clk  - clock, all state changes on rising edge
//             rst  - synchronous active-high reset
//             bus  - shift_right_seq_if slave modport (request + results)
//  Params   : WIDTH - data width (>= 2), CNTW - shift-amount width
//  Revision : 1.0  initial release
// ============================================================================
module shift_right_seq #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_right_seq_if.slave bus
);
    // Counter must be able to hold WIDTH itself (saturated shift amount).
    localparam int          CW      = $clog2(WIDTH + 1);
    localparam logic [31:0] C_WIDTH = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sreg_q,   sreg_d;
    logic             mode_q,   mode_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             cbit_q,   cbit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;

    logic [CNTW-1:0]  w_rd2;
    logic [CW-1:0]    w_k;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;

    assign w_rd2 = bus.Rd2;

    // Saturate the requested shift amount at WIDTH.
    assign w_k = (32'(w_rd2) >= C_WIDTH) ? CW'(WIDTH) : CW'(w_rd2);

    // In arithmetic mode the MSB is never overwritten, so it still holds the
    // original sign bit and can be replicated directly.
    assign w_fill    = mode_q & sreg_q[WIDTH-1];
    assign w_shifted = {w_fill, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        cbit_d   = cbit_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    sreg_d = bus.Rd1;
                    mode_d = bus.arith;
                    cnt_d  = w_k;
                    cbit_d = 1'b0;
                    if (w_k == '0) begin
                        // Zero-length shift completes immediately.
                        state_d  = S_DONE;
                        result_d = bus.Rd1;
                        carry_d  = 1'b0;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sreg_d = w_shifted;
                cbit_d = sreg_q[0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = w_shifted;
                    carry_d  = sreg_q[0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            cbit_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            cbit_q   <= cbit_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_right_seq
//  Purpose  : Self-checking bench for shift_right_seq: directed scenarios
//             followed by random traffic, compared every cycle against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_right_seq;
    localparam int W = 4;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_right_seq_if #(.WIDTH(W), .CNTW(C)) bus ();

    shift_right_seq #(.WIDTH(W), .CNTW(C)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining busy cycles of the current operation
    // (including the done cycle) plus the precomputed outcome.
    int           m_rem   = 0;
    logic [W-1:0] m_pres  = '0;
    logic         m_pcar  = 1'b0;
    logic [W-1:0] exp_res = '0;
    logic         exp_car = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_accept(input logic [W-1:0] a, input logic [C-1:0] b, input logic ar);
        int k;
        logic signed [W-1:0] s;
        k = (int'(b) > W) ? W : int'(b);
        s = a;
        m_pres = ar ? W'(s >>> k) : W'(a >> k);
        m_pcar = (k == 0) ? 1'b0 : a[k-1];
        m_rem  = k + 1;
    endfunction

    // One clock: drive inputs, advance model at the edge, check after it.
    task automatic cyc(input logic e, input logic r, input logic [W-1:0] a,
                       input logic [C-1:0] b, input logic ar);
        bus.en = e; bus.Rd1 = a; bus.Rd2 = b; bus.arith = ar; rst = r;
        @(posedge clk);
        if (r) begin
            m_rem = 0; exp_res = '0; exp_car = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (e) begin
            model_accept(a, b, ar);
        end
        if (m_rem == 1) begin
            exp_res = m_pres;
            exp_car = m_pcar;
        end
        #1;
        check_eq("busy",   32'(bus.busy),   32'(m_rem > 0));
        check_eq("done",   32'(bus.done),   32'(m_rem == 1));
        check_eq("result", 32'(bus.result), 32'(exp_res));
        check_eq("carry",  32'(bus.carry),  32'(exp_car));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        bus.en = 1'b1; bus.Rd1 = 4'b1011; bus.Rd2 = 4'd2; bus.arith = 1'b0;

        // V1: reset held two edges with en high
        cyc(1'b1, 1'b1, 4'b1011, 4'd2, 1'b0);
        cyc(1'b1, 1'b1, 4'b1011, 4'd2, 1'b0);
        idle(1);

        // V2: logical shift by 2
        cyc(1'b1, 1'b0, 4'b1011, 4'd2, 1'b0);
        idle(2);
        check_eq("v2_done",   32'(bus.done),   32'd1);
        check_eq("v2_result", 32'(bus.result), 32'b0010);
        check_eq("v2_carry",  32'(bus.carry),  32'd1);
        idle(2);

        // V3: arithmetic shift by 1, then by 0
        cyc(1'b1, 1'b0, 4'b1011, 4'd1, 1'b1);
        idle(1);
        check_eq("v3_result", 32'(bus.result), 32'b1101);
        check_eq("v3_carry",  32'(bus.carry),  32'd1);
        idle(1);
        cyc(1'b1, 1'b0, 4'b1011, 4'd0, 1'b1);
        check_eq("v3_k0_done",   32'(bus.done),   32'd1);
        check_eq("v3_k0_result", 32'(bus.result), 32'b1011);
        check_eq("v3_k0_carry",  32'(bus.carry),  32'd0);
        idle(2);

        // V4: saturated shift, arithmetic then logical
        cyc(1'b1, 1'b0, 4'b1000, 4'd9, 1'b1);
        idle(4);
        check_eq("v4a_result", 32'(bus.result), 32'b1111);
        check_eq("v4a_carry",  32'(bus.carry),  32'd1);
        idle(1);
        cyc(1'b1, 1'b0, 4'b1000, 4'd9, 1'b0);
        idle(4);
        check_eq("v4l_result", 32'(bus.result), 32'b0000);
        check_eq("v4l_carry",  32'(bus.carry),  32'd1);
        idle(2);

        // V5: new request mid-shift is ignored; then en held high
        cyc(1'b1, 1'b0, 4'b1111, 4'd3, 1'b0);
        cyc(1'b0, 1'b0, 4'b1111, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'b0101, 4'd0, 1'b1);
        cyc(1'b0, 1'b0, 4'b0101, 4'd0, 1'b1);
        check_eq("v5_result", 32'(bus.result), 32'b0001);
        for (int i = 0; i < 24; i++)
            cyc(1'b1, 1'b0, 4'(i * 5 + 3), 4'(i % 6), 1'(i % 2));
        idle(3);

        // V6: reset mid-operation, then a fresh operation
        cyc(1'b1, 1'b0, 4'b0110, 4'd4, 1'b0);
        cyc(1'b0, 1'b0, 4'b0110, 4'd4, 1'b0);
        cyc(1'b0, 1'b1, 4'b0110, 4'd4, 1'b0);
        check_eq("v6_busy",   32'(bus.busy),   32'd0);
        check_eq("v6_result", 32'(bus.result), 32'd0);
        idle(4);
        cyc(1'b1, 1'b0, 4'b0110, 4'd1, 1'b0);
        idle(1);
        check_eq("v6_result2", 32'(bus.result), 32'b0011);
        check_eq("v6_carry2",  32'(bus.carry),  32'd0);
        idle(2);

        // Random traffic: operands change every cycle, occasional reset
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 50) == 0,
                4'($urandom), 4'($urandom), 1'($urandom));
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of Rd1 and result.
REQ-002 The block SHALL have parameter CNTW, default 4, giving the width of the shift-amount input Rd2.
REQ-003 clk  input  1  The single clock; all state SHALL change only on its rising edge.
REQ-004 rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 en  input  1  Start request; sampled on each rising edge of clk.
REQ-006 Rd1  input  WIDTH  Operand to be shifted right.
REQ-007 Rd2  input  CNTW  Shift amount, unsigned.
REQ-008 arith  input  1  Fill select: 0 = logical (zero fill), 1 = arithmetic (fill with Rd1[WIDTH-1]).
REQ-009 busy  output  1  High while an operation is in progress.
REQ-010 done  output  1  One-cycle pulse marking a completed operation.
REQ-011 result  output  WIDTH  Registered result of the last completed operation.
REQ-012 carry  output  1  Last bit shifted out of the last completed operation.

Function
REQ-013 The block SHALL implement three states: IDLE, SHIFT and DONE; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 In IDLE, en=1 at a clock edge SHALL accept the operation and latch Rd1 into an internal shift register, arith into a mode register, and k = min(Rd2, WIDTH) into a down-counter.
REQ-015 The acceptance edge SHALL set the next state to SHIFT if k>0, or to DONE if k=0.
REQ-016 In SHIFT, each edge SHALL shift the internal register right by one bit.
- Vacated MSB: 0 when mode=0, the latched original MSB when mode=1.
- The shifted-out LSB SHALL be captured into an internal carry bit.
- The counter SHALL decrement by 1.
REQ-017 In SHIFT, the edge at which the counter equals 1 SHALL perform the final shift and set the next state to DONE.
REQ-018 On entry to DONE, result and carry SHALL be loaded with the final shift-register value and the captured carry bit.
REQ-019 For k=0, result SHALL equal Rd1 and carry SHALL be 0.
REQ-020 done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return the state to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the (k+1)th rising edge, counting the acceptance edge as the first.
REQ-022 en SHALL be ignored in SHIFT and DONE: no queuing and no restart. A new operation SHALL be accepted only from IDLE, so the minimum spacing between acceptances is k+2 edges.
REQ-023 Rd1, Rd2 and arith SHALL be sampled only at the acceptance edge; changes to them during busy SHALL NOT affect the operation in progress.
REQ-024 result and carry SHALL hold their values from the last completion until the next DONE entry.
REQ-025 Shift amounts of WIDTH or more SHALL saturate to WIDTH shifts.
- result = all zeros when mode=0.
- result = all copies of the original MSB when mode=1.
- carry = original Rd1[WIDTH-1].

Reset
REQ-026 When rst=1 at an edge, the block SHALL go to IDLE and clear busy, done, result, carry, the counter and the shift register to 0. rst SHALL take priority over en and over any operation in progress.
REQ-027 An operation interrupted by rst SHALL produce no done pulse and SHALL NOT update result or carry.
REQ-028 en asserted in the same cycle as rst SHALL be ignored; the first acceptance SHALL occur at the first edge with rst=0 and en=1.

Verification
REQ-029 The bench SHALL cover scenario V1: assert rst for 2 edges with en=1 -> busy=0, done=0, result=0000, carry=0, and no acceptance.
REQ-030 The bench SHALL cover scenario V2: Rd1=1011, Rd2=2, arith=0, en pulse -> busy high for 3 cycles; done high in the cycle after the 3rd edge; result=0010, carry=1.
REQ-031 The bench SHALL cover scenario V3: Rd1=1011, Rd2=1, arith=1 -> done after the 2nd edge; result=1101, carry=1. The same operands with Rd2=0 -> done after the 1st edge; result=1011, carry=0.
REQ-032 The bench SHALL cover scenario V4: Rd1=1000, Rd2=9, arith=1 -> done after the 5th edge; result=1111, carry=1. The same operands with arith=0 -> result=0000, carry=1.
REQ-033 The bench SHALL cover scenario V5: start Rd1=1111, Rd2=3; pulse en with new operands mid-shift -> the second request is ignored and result=0001. Hold en=1 continuously -> re-acceptance only from IDLE, one done pulse per operation.
REQ-034 The bench SHALL cover scenario V6: start Rd1=0110, Rd2=4; assert rst after the 2nd edge -> IDLE, result=0000, no done pulse. A following operation with Rd1=0110, Rd2=1 -> result=0011, carry=0.
